// File: rtl/seven_seg_mux.sv
// seven_seg_mux: multiplexed seven-segment controller with sequential binary-to-BCD or hex
// conversion, leading-zero blanking, overflow dashes and tear-free display updates.
module seven_seg_mux #(
    parameter int N_DIGITS    = 4,
    parameter int VALUE_W     = 16,
    parameter int REFRESH_DIV = 262144
) (
    input  logic                clk_100mhz,
    input  logic                reset,
    input  logic [VALUE_W-1:0]  value_in,
    input  logic                load,
    input  logic                hex_mode,
    input  logic                blank_lz,
    input  logic [N_DIGITS-1:0] dp_in,
    output logic                busy,
    output logic [N_DIGITS-1:0] Anode_activate,
    output logic [6:0]          LED_out,
    output logic                dp_out
);
    localparam int BW = 4 * N_DIGITS;
    localparam int CW = $clog2(VALUE_W);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [63:0] DEC_LIM = 64'(10 ** N_DIGITS);
    // Active-low a..g patterns, digit F in the top slot down to digit 0 at the bottom.
    localparam logic [111:0] SEG_ROM = {7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
                                        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
                                        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
                                        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state_q, state_d;
    logic [VALUE_W-1:0]  val_q, val_d;
    logic [BW-1:0]       bcd_q, bcd_d, adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d, blz_q, blz_d;
    logic [BW-1:0]       code_q, code_d;
    logic [N_DIGITS-1:0] blank_q, blank_d, dash_q, dash_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          led_q, led_d;
    logic                dp_q, dp_d;
    logic [3:0]          digit;
    logic                accept, seen, tc;

    always_ff @(posedge clk_100mhz) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = hex_mode ? COMMIT : SHIFT;
            SHIFT:   if (cnt_q == CW'(VALUE_W - 1)) state_d = COMMIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        accept = load & ~busy;
    end

    always_comb begin
        val_d   = val_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        blz_d   = blz_q;
        code_d  = code_q;
        blank_d = blank_q;
        dash_d  = dash_q;
        seen    = 1'b0;
        for (int i = 0; i < N_DIGITS; i++)
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        if (accept) begin
            val_d = value_in;
            bcd_d = hex_mode ? BW'(value_in) : '0;
            cnt_d = '0;
            ovf_d = hex_mode ? ((64'(value_in) >> BW) != '0) : (64'(value_in) >= DEC_LIM);
            blz_d = blank_lz;
        end
        if (state_q == SHIFT) begin
            bcd_d = {adj[BW-2:0], val_q[VALUE_W-1]};
            val_d = val_q << 1;
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == COMMIT) begin
            code_d = bcd_q;
            for (int i = N_DIGITS - 1; i >= 0; i--) begin
                seen       = seen | (bcd_q[4*i +: 4] != 4'd0) | (i == 0);
                blank_d[i] = blz_q & ~seen;
                dash_d[i]  = ovf_q;
            end
        end
    end

    always_comb begin
        tc    = (pre_q == PW'(REFRESH_DIV - 1));
        pre_d = tc ? '0 : pre_q + 1'b1;
        idx_d = tc ? ((idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1) : idx_q;
        digit = code_q[4*idx_q +: 4];
        an_d  = ~(N_DIGITS'(1) << idx_q);
        led_d = dash_q[idx_q] ? 7'b1111110 : blank_q[idx_q] ? 7'b1111111 : SEG_ROM[digit*7 +: 7];
        dp_d  = ~dp_in[idx_q];
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            val_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            blz_q   <= 1'b0;
            code_q  <= '0;
            blank_q <= '0;
            dash_q  <= '0;
            pre_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            led_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            val_q   <= val_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            blz_q   <= blz_d;
            code_q  <= code_d;
            blank_q <= blank_d;
            dash_q  <= dash_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            led_q   <= led_d;
            dp_q    <= dp_d;
        end
    end

    assign Anode_activate = an_q;
    assign LED_out        = led_q;
    assign dp_out         = dp_q;
endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed checks of reset, scan, decimal/hex conversion, blanking,
// overflow, load dropping and mid-conversion reset.
module tb_seven_seg_mux;
    logic        clk_100mhz = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        hex_mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = 4'b0100;
    logic        busy;
    logic [3:0]  Anode_activate;
    logic [6:0]  LED_out;
    logic        dp_out;
    int          checks = 0;
    int          failures = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    seven_seg_mux #(.N_DIGITS(4), .VALUE_W(16), .REFRESH_DIV(4)) dut (
        .clk_100mhz(clk_100mhz), .reset(reset), .value_in(value_in), .load(load),
        .hex_mode(hex_mode), .blank_lz(blank_lz), .dp_in(dp_in), .busy(busy),
        .Anode_activate(Anode_activate), .LED_out(LED_out), .dp_out(dp_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic hex, input logic blz,
                           input logic zero_chk, output int n);
        int bad;
        bad = 0;
        @(negedge clk_100mhz);
        value_in = v; hex_mode = hex; blank_lz = blz; load = 1'b1;
        @(negedge clk_100mhz);
        load = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (LED_out !== 7'b0000001) bad++;
            @(negedge clk_100mhz);
        end
        if (zero_chk) check("stable_while_busy", bad + int'(LED_out !== 7'b0000001), 0);
    endtask

    task automatic expect_digits(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                                 input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] exp_seg [4];
        logic [3:0] an_exp;
        int t;
        exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
        @(negedge clk_100mhz);
        for (int d = 0; d < 4; d++) begin
            an_exp = ~(4'b0001 << d);
            t = 0;
            while (Anode_activate !== an_exp && t < 40) begin
                @(negedge clk_100mhz);
                t++;
            end
            check($sformatf("%s_an%0d", tag, d), Anode_activate, an_exp);
            check($sformatf("%s_seg%0d", tag, d), LED_out, exp_seg[d]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] an_exp;
        repeat (3) @(negedge clk_100mhz);
        check("rst_an", Anode_activate, 4'b1111);
        check("rst_led", LED_out, 7'b1111111);
        check("rst_dp", dp_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk_100mhz);
        check("first_an", Anode_activate, 4'b1110);
        check("first_led", LED_out, 7'b0000001);
        check("first_busy", busy, 1'b0);
        for (int k = 1; k < 17; k++) begin
            @(negedge clk_100mhz);
            an_exp = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("scan_an_%0d", k), Anode_activate, an_exp);
            check($sformatf("scan_dp_%0d", k), dp_out, ((k / 4) % 4 == 2) ? 1'b0 : 1'b1);
        end

        do_load(16'd1234, 1'b0, 1'b0, 1'b1, n);
        check("busy_dec", n, 17);
        expect_digits("d1234", 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100);

        do_load(16'd7, 1'b0, 1'b1, 1'b0, n);
        expect_digits("d7_blz", 7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111);
        do_load(16'd7, 1'b0, 1'b0, 1'b0, n);
        expect_digits("d7", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111);

        do_load(16'd10000, 1'b0, 1'b0, 1'b0, n);
        expect_digits("ovf", 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);

        do_load(16'hBEEF, 1'b1, 1'b0, 1'b0, n);
        check("busy_hex", n, 1);
        expect_digits("hex", 7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000);

        @(negedge clk_100mhz);
        value_in = 16'd1111; hex_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk_100mhz);
        load = 1'b0;
        repeat (2) @(negedge clk_100mhz);
        value_in = 16'd2222; load = 1'b1;
        @(negedge clk_100mhz);
        load = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk_100mhz);
            n++;
        end
        check("drop_idle", busy, 1'b0);
        expect_digits("drop", 7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111);

        @(negedge clk_100mhz);
        value_in = 16'd9999; load = 1'b1;
        @(negedge clk_100mhz);
        load = 1'b0;
        repeat (4) @(negedge clk_100mhz);
        reset = 1'b1;
        @(negedge clk_100mhz);
        check("abort_busy", busy, 1'b0);
        check("abort_an", Anode_activate, 4'b1111);
        reset = 1'b0;
        expect_digits("abort", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seven_seg_mux.md
# seven_seg_mux

Parametrised multiplexed seven-segment display controller for the board's display path. It converts a binary value to BCD sequentially with shift-add-3, or passes it through as hex nibbles. It then scans N_DIGITS common-anode digits with active-low segments. Compared with the fixed 4-digit combinational-divide display driver, it adds a load/busy handshake, hex mode, leading-zero blanking, overflow indication, decimal points and tear-free updates.

## Interface
- N_DIGITS, 4: number of digits (2..8).
- VALUE_W, 16: width of value_in (4..32).
- REFRESH_DIV, 262144: clk_100mhz cycles each digit stays active (≥2).

- clk_100mhz  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- value_in  in  VALUE_W  value to display; captured on load accept.
- load  in  1  single-cycle request to start a conversion.
- hex_mode  in  1  1 = hex nibbles, 0 = decimal; captured with value_in.
- blank_lz  in  1  1 = blank leading zeros; captured with value_in.
- dp_in  in  N_DIGITS  decimal point per digit, active-high; sampled live.
- busy  out  1  conversion in progress; load is ignored while high.
- Anode_activate  out  N_DIGITS  active-low digit enable; bit 0 = rightmost (least significant) digit.
- LED_out  out  7  active-low segments, bit 6..0 = a..g.
- dp_out  out  1  active-low decimal point for the active digit.

## Operation
- Accept: when load=1 and busy=0, the block captures value_in, hex_mode and blank_lz, and computes the overflow flag.
  - Decimal overflow: value ≥ 10^N_DIGITS.
  - Hex overflow: any bit above 4*N_DIGITS-1 is set.
- States: IDLE, SHIFT, COMMIT.
  - IDLE→SHIFT on decimal accept.
  - IDLE→COMMIT on hex accept.
  - SHIFT runs VALUE_W iterations. Each iteration adds 3 to every BCD digit ≥5, then shifts left one bit, taking the value MSB. The BCD register is 4*N_DIGITS wide; excess bits are discarded, which is harmless because overflow masks the result.
  - SHIFT→COMMIT after iteration VALUE_W. COMMIT→IDLE always.
- COMMIT writes the display register in one edge, so the display never shows a partial result. For each digit it stores a 4-bit code plus blank and dash flags.
  - Overflow: every digit shows a dash (1111110).
  - blank_lz=1: every digit above the most significant nonzero digit is blanked (1111111). Digit 0 is never blanked.
- Segment codes:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100.
  - A:0001000, b:1100000, C:0110001, d:1000010, E:0110000, F:0111000.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1.
  - At terminal count the scan index increments 0..N_DIGITS-1 and wraps to 0.
- Outputs are registered from the scan index, the display register and dp_in:
  - Anode_activate = ~(1<<idx).
  - LED_out = segment code of digit idx.
  - dp_out = ~dp_in[idx].

## Timing
- Reset values:
  - busy=0, state IDLE, prescaler=0, scan index=0.
  - Display register: all digits '0', no blanking.
  - Anode_activate all ones, LED_out=1111111, dp_out=1.
- In the first cycle after reset deasserts, the outputs show digit 0 = '0': Anode_activate=~1, LED_out=0000001.
- Load accepted at edge t:
  - busy=1 from t.
  - Decimal: busy stays high for VALUE_W+1 cycles (VALUE_W SHIFT cycles + 1 COMMIT).
  - Hex: busy stays high for 1 cycle.
  - The display register updates on the edge where busy falls. Outputs reflect it one cycle later.
- A load while busy=1 is dropped, including a load on the COMMIT cycle. Loads do not queue.
- The scan and prescaler are never stalled by conversions.
- Each digit is active for exactly REFRESH_DIV cycles. Output registers add 1 cycle of latency relative to the scan index.
- Reset mid-conversion aborts it, returns to IDLE and clears the display to '0' in the same edge.
- Changing dp_in appears on the outputs 1 cycle after it is sampled for the active digit.

## Test plan
- Reset release (REFRESH_DIV=4, N_DIGITS=4) -> Anode_activate=1110, LED_out=0000001, busy=0. The anode then steps 1101, 1011, 0111, 1110 every 4 cycles.
- Decimal load 1234, blank_lz=0 -> busy high for exactly 17 cycles. Digits 3..0 then show 1, 2, 3, 4 (1001111, 0010010, 0000110, 1001100). Outputs are unchanged while busy.
- Decimal load 7, blank_lz=1 -> digit 0 shows 0001111; digits 1..3 show 1111111. The same load with blank_lz=0 shows 0000001 on digits 1..3.
- Decimal load 10000 -> all four digits show 1111110. Hex load 16'hBEEF -> busy for 1 cycle, then digits 3..0 show b, E, E, F.
- Load 1111, then load 2222 three cycles later -> the second load is ignored and the display shows 1111. Reset 5 cycles into a conversion -> busy=0 next cycle and all digits show '0'.
- dp_in=0100 -> dp_out=0 only while Anode_activate=1011; otherwise dp_out=1.
